// File: rtl/elevator_sched.sv
// Single-car elevator scheduler: prescaled motion ticks, SCAN call service, overload hold and rescue halt.
// Define ELEV_SEVSEG_EN to add the two-digit active-low seven-segment floor display output.
module elevator_sched #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int TICK_DIV   = 50_000_000,
    parameter int DOOR_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  over_weight,
    input  logic                  rescue,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  up,
    output logic                  down,
    output logic                  open_door,
    output logic                  weight_alert,
    output logic                  rescue_alert,
    output logic                  busy,
    output logic                  req_err
`ifdef ELEV_SEVSEG_EN
    ,
    output logic [13:0]           seg
`endif
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMR_W = (DOOR_TICKS > 0) ? $clog2(DOOR_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(DOOR_TICKS);
    localparam logic [FLOOR_W:0]   FLOOR_LIM = (FLOOR_W + 1)'(NUM_FLOORS);

    typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_DOOR, S_HALT} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    dir_up_q, dir_up_d;
    logic                    up_q, down_q, open_q, weight_q, rescue_alert_q, busy_q, req_err_q;

    logic                    tick, req_ok, req_in_range, req_legal, req_err_d, door_recall;
    logic                    above, below;
    logic [NUM_FLOORS-1:0]   cap_mask, pend_w;
    logic [FLOOR_W-1:0]      floor_up, floor_dn;

    assign tick         = (cnt_q == CNT_MAX);
    assign req_ok       = req_valid && (state_q != S_HALT) && !rescue;
    assign req_in_range = ({1'b0, req_floor} < FLOOR_LIM);
    assign req_legal    = req_ok && req_in_range;
    assign req_err_d    = req_ok && !req_in_range;
    // A call for the open-door floor is absorbed by extending the door instead of latching a bit.
    assign door_recall  = req_legal && (state_q == S_DOOR) && (req_floor == cur_floor_q);
    assign floor_up     = cur_floor_q + 1'b1;
    assign floor_dn     = cur_floor_q - 1'b1;

    always_comb begin
        cap_mask = '0;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cap_mask[i] = req_legal && !door_recall && (req_floor == FLOOR_W'(i));
        end
        pend_w = pending_q | cap_mask;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_w[i] && (i > int'(cur_floor_q))) above = 1'b1;
            if (pend_w[i] && (i < int'(cur_floor_q))) below = 1'b1;
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        pending_d   = pend_w;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        if (rescue) begin
            state_d   = S_HALT;
            pending_d = '0;
            timer_d   = '0;
        end else begin
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!over_weight) begin
                            if (pend_w[cur_floor_q]) begin
                                state_d                = S_DOOR;
                                timer_d                = TMR_LOAD;
                                pending_d[cur_floor_q] = 1'b0;
                            end else if (above) begin
                                state_d  = S_UP;
                                dir_up_d = 1'b1;
                            end else if (below) begin
                                state_d  = S_DOWN;
                                dir_up_d = 1'b0;
                            end
                        end
                    end
                    S_UP: begin
                        cur_floor_d = floor_up;
                        if (pend_w[floor_up]) begin
                            state_d             = S_DOOR;
                            timer_d             = TMR_LOAD;
                            pending_d[floor_up] = 1'b0;
                        end
                    end
                    S_DOWN: begin
                        cur_floor_d = floor_dn;
                        if (pend_w[floor_dn]) begin
                            state_d             = S_DOOR;
                            timer_d             = TMR_LOAD;
                            pending_d[floor_dn] = 1'b0;
                        end
                    end
                    S_DOOR: begin
                        if (timer_q > TMR_W'(1)) begin
                            timer_d = timer_q - 1'b1;
                        end else if (over_weight) begin
                            timer_d = TMR_LOAD;
                        end else begin
                            timer_d = '0;
                            state_d = S_IDLE;
                            // SCAN: keep sweeping the last direction while it still has calls.
                            if (dir_up_q ? above : !below && above) begin
                                state_d  = S_UP;
                                dir_up_d = 1'b1;
                            end else if (below) begin
                                state_d  = S_DOWN;
                                dir_up_d = 1'b0;
                            end
                        end
                    end
                    S_HALT:  state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
            if (door_recall) begin
                state_d = S_DOOR;
                timer_d = TMR_LOAD;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            cur_floor_q    <= '0;
            pending_q      <= '0;
            timer_q        <= '0;
            dir_up_q       <= 1'b1;
            up_q           <= 1'b0;
            down_q         <= 1'b0;
            open_q         <= 1'b0;
            weight_q       <= 1'b0;
            rescue_alert_q <= 1'b0;
            busy_q         <= 1'b0;
            req_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= tick ? '0 : cnt_q + 1'b1;
            cur_floor_q    <= cur_floor_d;
            pending_q      <= pending_d;
            timer_q        <= timer_d;
            dir_up_q       <= dir_up_d;
            up_q           <= (state_d == S_UP);
            down_q         <= (state_d == S_DOWN);
            open_q         <= (state_d == S_DOOR);
            weight_q       <= over_weight && ((state_d == S_IDLE) || (state_d == S_DOOR));
            rescue_alert_q <= (state_d == S_HALT);
            busy_q         <= (state_d != S_IDLE);
            req_err_q      <= req_err_d;
        end
    end

    assign cur_floor    = cur_floor_q;
    assign pending      = pending_q;
    assign up           = up_q;
    assign down         = down_q;
    assign open_door    = open_q;
    assign weight_alert = weight_q;
    assign rescue_alert = rescue_alert_q;
    assign busy         = busy_q;
    assign req_err      = req_err_q;

`ifdef ELEV_SEVSEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign seg = {seg7(4'(int'(cur_floor_q) / 10)), seg7(4'(int'(cur_floor_q) % 10))};
`endif

endmodule

// File: tb/tb_elevator_sched.sv
// Self-checking bench for elevator_sched: scoreboard of expected stop floors plus per-scenario inline checks.
module tb_elevator_sched;

    localparam int NF = 8;
    localparam int TD = 4;
    localparam int DT = 2;
    localparam int FW = 4;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          over_weight;
    logic          rescue;
    logic [FW-1:0] cur_floor;
    logic [NF-1:0] pending;
    logic          up, down, open_door, weight_alert, rescue_alert, busy, req_err;

    int   checks   = 0;
    int   failures = 0;
    int   up_cyc, down_cyc, door_cyc;
    int   exp_q[$];
    logic door_prev;

    elevator_sched #(
        .NUM_FLOORS(NF),
        .FLOOR_W   (FW),
        .TICK_DIV  (TD),
        .DOOR_TICKS(DT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .over_weight (over_weight),
        .rescue      (rescue),
        .cur_floor   (cur_floor),
        .pending     (pending),
        .up          (up),
        .down        (down),
        .open_door   (open_door),
        .weight_alert(weight_alert),
        .rescue_alert(rescue_alert),
        .busy        (busy),
        .req_err     (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge; a door opening pops the next expected stop floor.
    task automatic step();
        @(negedge clk);
        if (up) up_cyc++;
        if (down) down_cyc++;
        if (open_door) door_cyc++;
        if (open_door && !door_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stop_unexpected floor=%0d expected=none", cur_floor);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cur_floor !== FW'(e)) begin
                    failures++;
                    $display("FAIL stop_order got=%0d expected=%0d", cur_floor, e);
                end
            end
        end
        door_prev = open_door;
    endtask

    task automatic call(input int f);
        req_valid = 1'b1;
        req_floor = FW'(f);
        step();
        req_valid = 1'b0;
        req_floor = '0;
    endtask

    task automatic run_to_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            failures++;
            $display("FAIL %s_timeout busy=%0b outstanding=%0d expected idle", name, busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_floor   = '0;
        over_weight = 1'b0;
        rescue      = 1'b0;
        door_prev   = 1'b0;
        repeat (3) step();
        checks++;
        if (cur_floor !== '0) begin failures++; $display("FAIL reset_floor got=%0d expected=0", cur_floor); end
        checks++;
        if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%h expected=0", pending); end
        checks++;
        if ({up, down, open_door} !== 3'b000) begin
            failures++; $display("FAIL reset_motion got=%b expected=000", {up, down, open_door});
        end
        checks++;
        if ({busy, req_err, weight_alert, rescue_alert} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b expected=0000", {busy, req_err, weight_alert, rescue_alert});
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_trip();
        int            fl[$];
        logic [FW-1:0] last;
        int            n = 0;
        up_cyc   = 0;
        door_cyc = 0;
        last     = '0;
        exp_q.push_back(3);
        call(3);
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            step();
            n++;
            if (cur_floor !== last) begin
                fl.push_back(int'(cur_floor));
                last = cur_floor;
            end
        end
        checks++;
        if (n >= 200) begin failures++; $display("FAIL basic_timeout cycles=%0d expected<200", n); end
        checks++;
        if (up_cyc != 3 * TD) begin failures++; $display("FAIL basic_up_cycles got=%0d expected=%0d", up_cyc, 3 * TD); end
        checks++;
        if (door_cyc != DT * TD) begin failures++; $display("FAIL basic_door_cycles got=%0d expected=%0d", door_cyc, DT * TD); end
        checks++;
        if (fl.size() != 3 || fl[0] != 1 || fl[1] != 2 || fl[2] != 3) begin
            failures++; $display("FAIL basic_floor_seq got=%p expected=1,2,3", fl);
        end
        checks++;
        if (pending !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_end got pending=%h busy=%0b expected pending=0 busy=0", pending, busy);
        end
    endtask

    task automatic test_scan_order();
        int n = 0;
        exp_q.push_back(5);
        exp_q.push_back(6);
        exp_q.push_back(1);
        call(5);
        while (!(cur_floor == FW'(4) && up) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL scan_reach4 floor=%0d up=%0b expected floor=4 up=1", cur_floor, up); end
        call(6);
        call(1);
        down_cyc = 0;
        n = 0;
        while (exp_q.size() > 1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (down_cyc != 0) begin failures++; $display("FAIL scan_reversal down_cycles=%0d expected=0", down_cyc); end
        run_to_idle("scan");
        checks++;
        if (cur_floor !== FW'(1)) begin failures++; $display("FAIL scan_final_floor got=%0d expected=1", cur_floor); end
    endtask

    task automatic test_req_err();
        call(9);
        checks++;
        if (req_err !== 1'b1) begin failures++; $display("FAIL err9_pulse got=%0b expected=1", req_err); end
        checks++;
        if (pending !== '0) begin failures++; $display("FAIL err9_pending got=%h expected=0", pending); end
        step();
        checks++;
        if (req_err !== 1'b0) begin failures++; $display("FAIL err9_width got=%0b expected=0", req_err); end
        call(8);
        checks++;
        if (req_err !== 1'b1 || pending !== '0) begin
            failures++; $display("FAIL err8 got req_err=%0b pending=%h expected 1/0", req_err, pending);
        end
        step();
    endtask

    task automatic test_overweight();
        int n = 0;
        exp_q.push_back(1);
        call(1);
        while (!open_door && n < 20) begin
            step();
            n++;
        end
        over_weight = 1'b1;
        exp_q.push_back(5);
        call(5);
        repeat (5 * TD) step();
        checks++;
        if (open_door !== 1'b1 || cur_floor !== FW'(1)) begin
            failures++; $display("FAIL ow_hold got door=%0b floor=%0d expected door=1 floor=1", open_door, cur_floor);
        end
        checks++;
        if (weight_alert !== 1'b1) begin failures++; $display("FAIL ow_alert got=%0b expected=1", weight_alert); end
        checks++;
        if (pending !== NF'(8'h20)) begin failures++; $display("FAIL ow_pending got=%h expected=20", pending); end
        over_weight = 1'b0;
        n = 0;
        while (!up && n < 3 * TD) begin
            step();
            n++;
        end
        checks++;
        if (!up || n < 1 || n > DT * TD) begin
            failures++; $display("FAIL ow_depart cycles=%0d up=%0b expected up within %0d cycles", n, up, DT * TD);
        end
        over_weight = 1'b1;
        step();
        step();
        checks++;
        if (weight_alert !== 1'b0 || up !== 1'b1) begin
            failures++; $display("FAIL ow_moving got alert=%0b up=%0b expected alert=0 up=1", weight_alert, up);
        end
        over_weight = 1'b0;
        run_to_idle("overweight");
    endtask

    task automatic test_door_recall();
        int n = 0;
        door_cyc = 0;
        exp_q.push_back(5);
        call(5);
        while (!open_door && n < 20) begin
            step();
            n++;
        end
        repeat (TD) step();
        call(5);
        checks++;
        if (pending !== '0) begin failures++; $display("FAIL recall_pending got=%h expected=0", pending); end
        run_to_idle("recall");
        checks++;
        if (door_cyc != 3 * TD) begin failures++; $display("FAIL recall_door_cycles got=%0d expected=%0d", door_cyc, 3 * TD); end
    endtask

    task automatic test_rescue();
        int n = 0;
        call(7);
        while (!up && n < 20) begin
            step();
            n++;
        end
        rescue = 1'b1;
        step();
        checks++;
        if (rescue_alert !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL rescue_enter got alert=%0b busy=%0b expected 1/1", rescue_alert, busy);
        end
        checks++;
        if ({up, down, open_door} !== 3'b000 || pending !== '0) begin
            failures++; $display("FAIL rescue_halt got motion=%b pending=%h expected 000/0", {up, down, open_door}, pending);
        end
        call(2);
        call(12);
        checks++;
        if (req_err !== 1'b0 || pending !== '0) begin
            failures++; $display("FAIL rescue_ignore got req_err=%0b pending=%h expected 0/0", req_err, pending);
        end
        repeat (2 * TD) step();
        checks++;
        if (rescue_alert !== 1'b1 || cur_floor !== FW'(5)) begin
            failures++; $display("FAIL rescue_hold got alert=%0b floor=%0d expected 1/5", rescue_alert, cur_floor);
        end
        rescue = 1'b0;
        n = 0;
        while (rescue_alert && n < 2 * TD) begin
            step();
            n++;
        end
        checks++;
        if (rescue_alert !== 1'b0 || n > TD) begin
            failures++; $display("FAIL rescue_exit got alert=%0b cycles=%0d expected 0 within %0d", rescue_alert, n, TD);
        end
        checks++;
        if (busy !== 1'b0 || cur_floor !== FW'(5)) begin
            failures++; $display("FAIL rescue_idle got busy=%0b floor=%0d expected 0/5", busy, cur_floor);
        end
    endtask

    task automatic test_reset_mid_door();
        int n = 0;
        exp_q.push_back(5);
        call(5);
        while (!open_door && n < 20) begin
            step();
            n++;
        end
        call(2);
        reset = 1'b0;
        #1;
        checks++;
        if (cur_floor !== '0 || open_door !== 1'b0) begin
            failures++; $display("FAIL rst_door got floor=%0d door=%0b expected 0/0", cur_floor, open_door);
        end
        checks++;
        if (pending !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_pending got pending=%h busy=%0b expected 0/0", pending, busy);
        end
        step();
        reset = 1'b1;
        exp_q.push_back(1);
        call(1);
        n = 1;
        while (!up && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != TD) begin failures++; $display("FAIL rst_first_tick cycles=%0d expected=%0d", n, TD); end
        run_to_idle("post_reset");
        checks++;
        if (cur_floor !== FW'(1) || pending !== '0) begin
            failures++; $display("FAIL rst_trip got floor=%0d pending=%h expected 1/0", cur_floor, pending);
        end
    endtask

    initial begin
        test_reset();
        test_basic_trip();
        test_scan_order();
        test_req_err();
        test_overweight();
        test_door_recall();
        test_rescue();
        test_reset_mid_door();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_sched.md
ELEVATOR_SCHED -- requirements
Module: elevator_sched

Interface
REQ-001 Parameter NUM_FLOORS, default 16: number of served floors, legal range 2..64.
REQ-002 Parameter FLOOR_W, default $clog2(NUM_FLOORS): floor-index width.
REQ-003 Parameter TICK_DIV, default 50_000_000: clk cycles per motion tick; internal prescaler, no external divider.
REQ-004 Parameter DOOR_TICKS, default 3: ticks the door stays open per stop.
REQ-005 Port: clk  in  1  single clock; all logic on rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: req_valid  in  1  floor call strobe, sampled every cycle.
REQ-008 Port: req_floor  in  FLOOR_W  requested floor, qualified by req_valid.
REQ-009 Port: over_weight  in  1  cabin overload sensor, level.
REQ-010 Port: rescue  in  1  emergency halt, level.
REQ-011 Port: cur_floor  out  FLOOR_W  current cabin floor.
REQ-012 Port: pending  out  NUM_FLOORS  outstanding-call bitmask, bit i = floor i.
REQ-013 Port: up, down, open_door  out  1 each  cabin moving up / moving down / door open.
REQ-014 Port: weight_alert, rescue_alert, busy, req_err  out  1 each  overload, halted, not-idle, illegal-request pulse.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1; internal tick is high one cycle when count = TICK_DIV-1; all state transitions occur on tick cycles only, except request capture and rescue entry.
REQ-016 Capture: req_valid=1 with req_floor<NUM_FLOORS sets pending[req_floor] on the next edge; req_floor>=NUM_FLOORS -> pending unchanged, req_err=1 for exactly one cycle.
REQ-017 States: IDLE, UP, DOWN, DOOR, HALT; up=1 only in UP, down=1 only in DOWN, open_door=1 only in DOOR, busy=1 in every state except IDLE; all outputs registered.
REQ-018 IDLE on tick: over_weight=1 -> stay IDLE; pending[cur_floor] -> DOOR, clear bit; else any pending above -> UP; else any below -> DOWN; else stay.
REQ-019 UP on tick: cur_floor+1; if pending[cur_floor+1] -> DOOR and clear that bit same edge; else stay UP. DOWN mirrors with -1.
REQ-020 cur_floor never leaves 0..NUM_FLOORS-1; UP entered only with a call above, DOWN only with a call below.
REQ-021 DOOR: timer loads DOOR_TICKS on entry, decrements per tick; at zero with over_weight=0 -> exit decision; with over_weight=1 timer reloads and door stays open.
REQ-022 DOOR exit (SCAN): last direction up and call above -> UP; else call below -> DOWN; else call above -> UP; else IDLE. Mirror when last direction down; last direction resets to up.
REQ-023 Call for cur_floor arriving while in DOOR: bit not set, door timer reloads to DOOR_TICKS.
REQ-024 weight_alert = over_weight while state is IDLE or DOOR, else 0; over_weight during UP/DOWN ignored until next stop.
REQ-025 rescue=1 in any state -> HALT next edge without waiting for tick; pending cleared, up=down=open_door=0, rescue_alert=1; requests ignored (no req_err).
REQ-026 HALT exit: rescue=0 on a tick -> IDLE, rescue_alert=0, cur_floor retained.
REQ-027 Simultaneous req_valid and arrival at same floor: arrival clear wins, bit ends 0, door handles it.

Reset
REQ-028 reset=0 asynchronously forces IDLE, cur_floor=0, pending=0, prescaler=0, door timer=0, last direction up, all 1-bit outputs 0.
REQ-029 Reset asserted mid-motion or mid-door discards all calls; first tick occurs TICK_DIV cycles after release.

Configuration
REQ-030 Macro ELEV_SEVSEG_EN defined: extra output seg [13:0] = {tens, units} of cur_floor, active-low a..g, 0=1000000, 1=1111001 ... 9=0011000, combinational from cur_floor.
REQ-031 Macro ELEV_SEVSEG_EN undefined: seg port and decoder absent; all other behaviour identical.

Verification (NUM_FLOORS=8, TICK_DIV=4, DOOR_TICKS=2)
REQ-032 Reset, call floor 3 -> up=1 three ticks, cur_floor 1,2,3, open_door=1 two ticks, busy=0, pending=0.
REQ-033 At floor 4 moving up, calls 6 and 1 -> stops 6 then 1, never reverses before 6.
REQ-034 req_floor=9 -> req_err one cycle, pending unchanged; req_floor=5 with over_weight=1 in DOOR -> door held, weight_alert=1, departs after over_weight=0 plus 2 ticks.
REQ-035 rescue=1 while in UP -> next cycle HALT, pending=0, up=0, rescue_alert=1; rescue=0 -> IDLE on next tick, same floor.
REQ-036 reset=0 mid-DOOR at floor 5 -> immediate cur_floor=0, open_door=0, pending=0; with ELEV_SEVSEG_EN, cur_floor=5 shows seg=1000000_0010010.
